// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the Booth partial-product accumulator.
package booth_pkg;

    // Accumulator control states: collecting rows, or holding a finished product.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Number of radix-4 Booth rows per product for an n-bit multiplier.
    function automatic int rows(input int n);
        return n / 2;
    endfunction

    // Width of the row counter; kept at least one bit wide.
    function automatic int row_w(input int n);
        return (n / 2 > 1) ? $clog2(n / 2) : 1;
    endfunction

endpackage

// File: rtl/booth_pp_accumulator_if.sv
// Row-stream input and product output handshakes of booth_pp_accumulator.
// The err signal exists only when BOOTH_ACC_ERR_EN is defined.
interface booth_pp_accumulator_if #(
    parameter int N = 8
);
    logic             pp_valid;
    logic             pp_ready;
    logic [N:0]       pp_data;
    logic             pp_neg;
    logic             pp_last;
    logic             prod_valid;
    logic             prod_ready;
    logic [2*N-1:0]   prod;
`ifdef BOOTH_ACC_ERR_EN
    logic             err;
`endif

    // Producer of rows and consumer of products (testbench / surrounding logic).
    modport master (
        output pp_valid, pp_data, pp_neg, pp_last, prod_ready,
`ifdef BOOTH_ACC_ERR_EN
        input  err,
`endif
        input  pp_ready, prod_valid, prod
    );

    // The accumulator itself.
    modport slave (
        input  pp_valid, pp_data, pp_neg, pp_last, prod_ready,
`ifdef BOOTH_ACC_ERR_EN
        output err,
`endif
        output pp_ready, prod_valid, prod
    );

endinterface

// File: rtl/booth_row_align.sv
// Turns one decoded Booth row into its 2N-bit weighted term: sign-extend the
// one's-complement row, add the negate correction, shift left by 2*row.
module booth_row_align
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N:0]          pp_data_i,
    input  logic                pp_neg_i,
    input  logic [row_w(N)-1:0] row_i,
    output logic [2*N-1:0]      term_o
);
    localparam int ROWS = rows(N);
    localparam int RW   = row_w(N);

    logic [2*N-1:0] corrected;
    logic [2*N-1:0] shifted [ROWS];

    // Two's-complement row value at full product width.
    assign corrected = {{(N-1){pp_data_i[N]}}, pp_data_i} + {{(2*N-1){1'b0}}, pp_neg_i};

    // One constant shift per row position; the counter picks one below.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_shift
            assign shifted[gi] = corrected << (2 * gi);
        end
    endgenerate

    // Row select mux.
    always_comb begin
        term_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_i == RW'(r)) begin
                term_o = shifted[r];
            end
        end
    end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential accumulator for a radix-4 Booth partial-product stream.
// Accepts N/2 rows (one per cycle), sums the aligned terms and presents the
// 2N-bit product on a valid/ready output. Optional row-framing check is
// enabled by defining BOOTH_ACC_ERR_EN.
module booth_pp_accumulator
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    booth_pp_accumulator_if.slave  bus
);
    localparam int            ROWS     = rows(N);
    localparam int            RW       = row_w(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    state_t          state_q, state_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [2*N-1:0]  prod_q, prod_d;
    logic [RW-1:0]   row_q, row_d;
    logic            prod_valid_q, prod_valid_d;
    logic [2*N-1:0]  term;
    logic            pp_ready;
    logic            accept;
    logic            is_last_row;

    booth_row_align #(.N(N)) u_align (
        .pp_data_i (bus.pp_data),
        .pp_neg_i  (bus.pp_neg),
        .row_i     (row_q),
        .term_o    (term)
    );

    // Ready depends on state alone so the producer never sees a loop through pp_valid.
    assign pp_ready    = (state_q == ACCUM);
    assign accept      = bus.pp_valid & pp_ready;
    assign is_last_row = (row_q == LAST_ROW);

    // Next-state: accumulate rows in ACCUM, hold the product in DONE until taken.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        row_d        = row_q;
        prod_d       = prod_q;
        prod_valid_d = prod_valid_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (is_last_row) begin
                        prod_d       = acc_q + term;
                        prod_valid_d = 1'b1;
                        state_d      = DONE;
                        acc_d        = '0;
                        row_d        = '0;
                    end else begin
                        acc_d = acc_q + term;
                        row_d = row_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.prod_ready) begin
                    prod_valid_d = 1'b0;
                    state_d      = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State, accumulator, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            row_q        <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            row_q        <= row_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
        end
    end

    assign bus.pp_ready   = pp_ready;
    assign bus.prod_valid = prod_valid_q;
    assign bus.prod       = prod_q;

`ifdef BOOTH_ACC_ERR_EN
    logic err_q, err_d;

    // Framing error: pp_last must be set exactly on the counter's final row.
    always_comb begin
        err_d = err_q | (accept & (bus.pp_last ^ is_last_row));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`endif

endmodule
